// File: rtl/cmn_pwm_wrapper.sv
// cmn_pwm_wrapper: OPB-mapped 3-pair motor and brake PWM with test timer and latched over-current stop
module cmn_pwm_wrapper #(
  parameter int PWM_PERIOD = 625,
  parameter int TICK_DIV   = 2500
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        OPB_RE,
  input  logic        OPB_WE,
  input  logic [31:0] OPB_ADDR,
  input  logic [31:0] OPB_DI,
  output logic [31:0] OPB_DO,
  output logic [5:0]  mot_pwm_o,
  output logic [1:0]  brk_pwm_o,
  output logic        mot_en_out_o,
  output logic        brk_en_out_o,
  output logic        pwm_override_o,
  input  logic        mot_over_curr_i,
  input  logic        brk_over_curr_i
);
  localparam int CW = $clog2(PWM_PERIOD + 1);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int HALF = (PWM_PERIOD - 1) / 2;
  logic          r_me, r_be, r_tm, r_run, r_mf, r_bf, r_td;
  logic [7:0]    r_dur, r_tcnt;
  logic [8:0]    r_duty [4];
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tick;
  logic [5:0]    r_mot;
  logic [1:0]    r_brk;
  logic [31:0]   r_do;
  logic [3:0]    w_a, w_hi;
  logic [CW-1:0] w_tri;
  logic [31:0]   w_rd;
  logic          w_ctl, w_start, w_stop, w_tick, w_tdone, w_run_nxt, w_pwr;
  assign w_a       = OPB_ADDR[3:0];
  assign w_ctl     = OPB_WE && w_a == 4'd5;
  assign w_stop    = w_ctl & OPB_DI[1];
  assign w_start   = w_ctl & OPB_DI[0] & ~OPB_DI[1];
  assign w_tick    = r_run & r_tm & (r_tick == TW'(TICK_DIV - 1));
  assign w_tdone   = w_tick & ~w_start & ((9'(r_tcnt) + 9'd1) >= 9'(r_dur));
  assign w_run_nxt = ~mot_over_curr_i & ~brk_over_curr_i & ~w_stop & ~w_tdone & (w_start | r_run);
  // Outputs drop on the same edge that running clears, and stay low on the start edge
  assign w_pwr     = w_run_nxt & r_run;
  assign w_tri     = (r_cnt <= CW'(HALF)) ? r_cnt : CW'(PWM_PERIOD - 1) - r_cnt;
  always_comb begin
    w_hi = '0;
    for (int i = 0; i < 4; i++) w_hi[i] = 32'(w_tri) < 32'(r_duty[i]);
  end
  assign w_rd = (w_a == 4'd0) ? {16'b0, r_dur, 5'b0, r_tm, r_be, r_me} :
                (w_a >= 4'd1 && w_a <= 4'd4) ? {23'b0, r_duty[w_a[1:0] - 2'd1]} :
                (w_a == 4'd6) ? {28'b0, r_td, r_bf, r_mf, r_run} : '0;
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      {r_me, r_be, r_tm, r_run, r_mf, r_bf, r_td} <= '0;
      for (int i = 0; i < 4; i++) r_duty[i] <= '0;
      r_dur  <= '0;
      r_tcnt <= '0;
      r_cnt  <= '0;
      r_tick <= '0;
      r_mot  <= '0;
      r_brk  <= '0;
      r_do   <= '0;
    end else begin
      if (OPB_WE && w_a == 4'd0) begin
        r_me  <= OPB_DI[0];
        r_be  <= OPB_DI[1];
        r_tm  <= OPB_DI[2];
        r_dur <= OPB_DI[15:8];
      end
      for (int i = 0; i < 4; i++) if (OPB_WE && w_a == 4'(i + 1)) r_duty[i] <= OPB_DI[8:0];
      r_run <= w_run_nxt;
      r_mf  <= mot_over_curr_i | (r_mf & ~w_start);
      r_bf  <= brk_over_curr_i | (r_bf & ~w_start);
      r_td  <= w_tdone | (r_td & ~w_start);
      r_cnt <= (w_start || !r_run || r_cnt == CW'(PWM_PERIOD - 1)) ? '0 : r_cnt + 1'b1;
      if (w_start) begin
        r_tick <= '0;
        r_tcnt <= '0;
      end else if (r_run && r_tm) begin
        r_tick <= w_tick ? '0 : r_tick + 1'b1;
        r_tcnt <= r_tcnt + 8'(w_tick);
      end
      for (int i = 0; i < 3; i++) begin
        r_mot[2*i]   <= w_pwr & r_me & w_hi[i];
        r_mot[2*i+1] <= w_pwr & r_me & ~w_hi[i];
      end
      r_brk <= {w_pwr & r_be & ~w_hi[3], w_pwr & r_be & w_hi[3]};
      r_do  <= OPB_RE ? w_rd : '0;
    end
  end
  assign OPB_DO         = r_do;
  assign mot_pwm_o      = r_mot;
  assign brk_pwm_o      = r_brk;
  assign mot_en_out_o   = r_run & r_me;
  assign brk_en_out_o   = r_run & r_be;
  assign pwm_override_o = r_run;
  logic w_unused;
  assign w_unused = &{1'b0, OPB_ADDR[31:4], OPB_DI[31:16], OPB_DI[7:3]};
endmodule

// File: tb/tb_cmn_pwm_wrapper.sv
// tb_cmn_pwm_wrapper: randomized register, carrier, test-timer, fault and reset checks against a duty-count model
module tb_cmn_pwm_wrapper;
  localparam int TD = 20;
  localparam int PER = 625;
  logic        clk = 0, rst = 1, re = 0, we = 0, moc = 0, boc = 0;
  logic [31:0] addr = 0, di = 0, dout;
  logic [5:0]  mot;
  logic [1:0]  brk;
  logic        men, ben, ovr;
  logic [10:0] w_all;
  int          n_chk = 0, n_fail = 0;
  int          m_d [4];
  bit          m_me, m_be;
  assign w_all = {mot, brk, men, ben, ovr};
  cmn_pwm_wrapper #(.PWM_PERIOD(PER), .TICK_DIV(TD)) dut (
    .OPB_CLK(clk), .OPB_RST(rst), .OPB_RE(re), .OPB_WE(we), .OPB_ADDR(addr), .OPB_DI(di),
    .OPB_DO(dout), .mot_pwm_o(mot), .brk_pwm_o(brk), .mot_en_out_o(men), .brk_en_out_o(ben),
    .pwm_override_o(ovr), .mot_over_curr_i(moc), .brk_over_curr_i(boc)
  );
  always #5 clk = ~clk;
  initial begin
    #3ms;
    $display("FAIL timeout: simulation did not finish, got time %0t required < 3ms", $time);
    $fatal(1);
  end
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1; addr = {28'($urandom), a}; di = d;
    @(negedge clk);
    we = 0;
  endtask
  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    re = 1; addr = {28'($urandom), a};
    @(negedge clk);
    re = 0; d = dout;
  endtask
  task automatic test_reset();
    logic [31:0] v;
    rst = 1;
    #23;
    n_chk++;
    if (w_all !== 0 || dout !== 0) begin n_fail++; $display("FAIL reset_outputs: got %h/%h required 0/0", w_all, dout); end
    @(negedge clk); rst = 0;
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), v);
      n_chk++;
      if (v !== 0) begin n_fail++; $display("FAIL reset_reg[%0d]: got %h required 0", a, v); end
    end
  endtask
  task automatic test_regs();
    logic [31:0] exp [16], v, w;
    for (int a = 0; a < 16; a++) exp[a] = 0;
    repeat (3) begin
      for (int a = 0; a < 16; a++) begin
        if (a == 5) continue;
        w = $urandom;
        wr(4'(a), w);
        if (a == 0) exp[a] = w & 32'h0000_FF07;
        else if (a <= 4) exp[a] = w & 32'h0000_01FF;
      end
      for (int a = 0; a < 16; a++) begin
        rd(4'(a), v);
        n_chk++;
        if (v !== exp[a]) begin n_fail++; $display("FAIL reg_readback[%0d]: got %h required %h", a, v, exp[a]); end
      end
      @(negedge clk);
      n_chk++;
      if (dout !== 0) begin n_fail++; $display("FAIL do_idle: got %h required 0", dout); end
      n_chk++;
      if (w_all !== 0) begin n_fail++; $display("FAIL idle_outputs: got %h required 0", w_all); end
    end
  endtask
  task automatic test_carrier_counts();
    int hi [4], lo [4], eh, el;
    bit en;
    for (int k = 0; k < 4; k++) begin hi[k] = 0; lo[k] = 0; end
    repeat (PER) begin
      for (int k = 0; k < 3; k++) begin hi[k] += int'(mot[2*k]); lo[k] += int'(mot[2*k+1]); end
      hi[3] += int'(brk[0]); lo[3] += int'(brk[1]);
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      en = (k < 3) ? m_me : m_be;
      eh = en ? ((2 * m_d[k] >= PER) ? PER : 2 * m_d[k]) : 0;
      el = en ? PER - eh : 0;
      n_chk++;
      if (hi[k] !== eh || lo[k] !== el)
        begin n_fail++; $display("FAIL duty_count[%0d] d=%0d: got hi=%0d lo=%0d required hi=%0d lo=%0d", k, m_d[k], hi[k], lo[k], eh, el); end
    end
  endtask
  task automatic test_pwm(input int d0, d1, d2, db, input bit me, be, input logic [31:0] stop_val);
    logic [31:0] v;
    m_d[0] = d0; m_d[1] = d1; m_d[2] = d2; m_d[3] = db; m_me = me; m_be = be;
    wr(0, {30'b0, be, me});
    for (int k = 0; k < 4; k++) wr(4'(k + 1), 32'(m_d[k]));
    wr(5, 1);
    rd(6, v);
    n_chk++;
    if (v !== 1) begin n_fail++; $display("FAIL run_status: got %h required 1", v); end
    n_chk++;
    if ({men, ben, ovr} !== {me, be, 1'b1}) begin n_fail++; $display("FAIL enables: got %b required %b", {men, ben, ovr}, {me, be, 1'b1}); end
    test_carrier_counts();
    m_d[0] = $urandom_range(0, 511);
    wr(1, 32'(m_d[0]));
    @(negedge clk);
    test_carrier_counts();
    wr(5, stop_val);
    n_chk++;
    if (w_all !== 0) begin n_fail++; $display("FAIL stop_outputs: got %h required 0", w_all); end
    rd(6, v);
    n_chk++;
    if (v !== 0) begin n_fail++; $display("FAIL stop_status: got %h required 0", v); end
  endtask
  task automatic test_test_mode(input int dur);
    logic [31:0] v;
    int cnt, exp;
    exp = ((dur == 0) ? 1 : dur) * TD;
    wr(0, {16'b0, 8'(dur), 8'h07});
    wr(5, 1);
    cnt = 0;
    while (ovr && cnt < 2 * exp + 10) begin cnt++; @(negedge clk); end
    n_chk++;
    if (cnt !== exp) begin n_fail++; $display("FAIL test_duration dur=%0d: got %0d cycles required %0d", dur, cnt, exp); end
    n_chk++;
    if (w_all !== 0) begin n_fail++; $display("FAIL test_done_outputs: got %h required 0", w_all); end
    rd(6, v);
    n_chk++;
    if (v !== 8) begin n_fail++; $display("FAIL test_done_status: got %h required 8", v); end
  endtask
  task automatic test_fault(input bit b);
    logic [31:0] v, ef;
    ef = b ? 4 : 2;
    wr(0, 3);
    for (int k = 0; k < 4; k++) wr(4'(k + 1), 32'($urandom_range(1, 300)));
    wr(5, 1);
    repeat ($urandom_range(3, 40)) @(negedge clk);
    if (b) boc = 1; else moc = 1;
    @(negedge clk);
    n_chk++;
    if (w_all !== 0) begin n_fail++; $display("FAIL fault_outputs b=%0d: got %h required 0", b, w_all); end
    repeat (4) @(negedge clk);
    moc = 0; boc = 0;
    rd(6, v);
    n_chk++;
    if (v !== ef) begin n_fail++; $display("FAIL fault_status b=%0d: got %h required %h", b, v, ef); end
    wr(5, 1);
    rd(6, v);
    n_chk++;
    if (v !== 1 || ovr !== 1) begin n_fail++; $display("FAIL fault_restart b=%0d: got %h/%b required 1/1", b, v, ovr); end
    @(negedge clk);
    we = 1; addr = 5; di = 1;
    if (b) boc = 1; else moc = 1;
    @(negedge clk);
    we = 0; moc = 0; boc = 0;
    rd(6, v);
    n_chk++;
    if (v !== ef || w_all !== 0) begin n_fail++; $display("FAIL fault_with_start b=%0d: got %h/%h required %h/0", b, v, w_all, ef); end
  endtask
  task automatic test_reset_midrun();
    logic [31:0] v;
    wr(0, 3);
    for (int k = 0; k < 4; k++) wr(4'(k + 1), 32'(200));
    wr(5, 1);
    repeat ($urandom_range(5, 50)) @(negedge clk);
    #2 rst = 1;
    #1;
    n_chk++;
    if (w_all !== 0) begin n_fail++; $display("FAIL async_reset: got %h required 0", w_all); end
    @(negedge clk); rst = 0;
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), v);
      n_chk++;
      if (v !== 0) begin n_fail++; $display("FAIL post_reset_reg[%0d]: got %h required 0", a, v); end
    end
    n_chk++;
    if (w_all !== 0) begin n_fail++; $display("FAIL post_reset_outputs: got %h required 0", w_all); end
  endtask
  initial begin
    test_reset();
    test_regs();
    test_pwm(300, 200, 100, 100, 1, 1, 2);
    test_pwm(0, 313, 312, 1, 1, 1, 3);
    test_pwm(511, 0, 156, 313, 0, 1, 2);
    repeat (3) test_pwm($urandom_range(0, 400), $urandom_range(0, 400), $urandom_range(0, 400),
                        $urandom_range(0, 400), 1'($urandom), 1'($urandom), 2);
    test_test_mode(128);
    test_test_mode(0);
    test_test_mode($urandom_range(1, 5));
    test_fault(0);
    test_fault(1);
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
